exec_stage_mdu: RTL and testbench

- Parametrised next-generation execute stage for the 5-stage RISC-V pipeline.
- Keeps the forwarding muxes, ALU, branch-target adder and EX/MEM register.
- Adds an iterative multiply/divide unit (MDU) that stalls the front end while busy, plus EX flush.
- Sits between the ID/EX register and the memory stage; the hazard unit consumes StallE.

---
 rtl/exec_stage_mdu.sv | 200 ++++++++++++++++++++
 tb/tb_exec_stage_mdu.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage_mdu.sv
// Execute stage with forwarding, ALU, branch target, EX/MEM register and an
// iterative multiply/divide unit. Define EXEC_EARLY_OUT_EN for zero-operand early-out.
module exec_stage_mdu #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = $clog2(XLEN) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   RD1E,
  input  logic [XLEN-1:0]   RD2E,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   ImmExtE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              JumpE,
  input  logic              BranchE,
  input  logic              ALUSrcE,
  input  logic [1:0]        ResultSrcE,
  input  logic [3:0]        ALUControlE,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              FlushE,
  output logic [XLEN-1:0]   PCTargetE,
  output logic              PCSrcE,
  output logic              StallE,
  output logic [XLEN-1:0]   ALUResultM,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   PCPlus4M,
  output logic [REG_AW-1:0] RdM,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_hi, r_lo, r_b, r_a;
  logic [2:0]       r_op;
  logic             r_dz, r_neg_q, r_neg_r;

  logic [XLEN-1:0]  w_src_a, w_fwd_b, w_src_b, w_alu, w_mdu_res, w_result;
  logic [XLEN-1:0]  w_a_mag, w_b_mag, w_div_sub;
  logic [XLEN:0]    w_mul_sum, w_div_shift;
  logic             w_is_mdu, w_signed, w_b_zero, w_early, w_div_ge, w_stall, w_zero;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_src_a = RD1E;
    case (ForwardAE)
      2'b01:   w_src_a = ResultW;
      2'b10:   w_src_a = ALUResultM;
      default: w_src_a = RD1E;
    endcase
    w_fwd_b = RD2E;
    case (ForwardBE)
      2'b01:   w_fwd_b = ResultW;
      2'b10:   w_fwd_b = ALUResultM;
      default: w_fwd_b = RD2E;
    endcase
  end

  assign w_src_b   = ALUSrcE ? ImmExtE : w_fwd_b;
  assign PCTargetE = PCE + ImmExtE;

  always_comb begin
    w_alu = '0;
    case (ALUControlE[2:0])
      3'b000:  w_alu = w_src_a + w_src_b;
      3'b001:  w_alu = w_src_a - w_src_b;
      3'b010:  w_alu = w_src_a & w_src_b;
      3'b011:  w_alu = w_src_a | w_src_b;
      3'b101:  w_alu = {{(XLEN-1){1'b0}}, $signed(w_src_a) < $signed(w_src_b)};
      default: w_alu = '0;
    endcase
  end

  // 1010/1011 are single-cycle zero-result codes, not MDU operations.
  assign w_is_mdu = ALUControlE[3] & (ALUControlE[2] | ~ALUControlE[1]);
  assign w_signed = ALUControlE[2] & ~ALUControlE[0];
  assign w_a_mag  = (w_signed & w_src_a[XLEN-1]) ? -w_src_a : w_src_a;
  assign w_b_mag  = (w_signed & w_src_b[XLEN-1]) ? -w_src_b : w_src_b;
  assign w_b_zero = (w_src_b == '0);

`ifdef EXEC_EARLY_OUT_EN
  logic w_a_zero;
  assign w_a_zero = (w_src_a == '0);
  assign w_early  = ALUControlE[2] ? w_b_zero : (w_a_zero | w_b_zero);
`else
  assign w_early  = 1'b0;
`endif

  // One shift-add or restoring-divide step on the latched operands.
  assign w_mul_sum   = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_b}) : {1'b0, r_hi};
  assign w_div_shift = {r_hi, r_lo[XLEN-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
  assign w_div_sub   = w_div_shift[XLEN-1:0] - r_b;

  always_comb begin
    w_mdu_res = '0;
    case (r_op)
      3'b000:  w_mdu_res = r_lo;
      3'b001:  w_mdu_res = r_hi;
      3'b100:  w_mdu_res = r_dz ? '1 : (r_neg_q ? -r_lo : r_lo);
      3'b101:  w_mdu_res = r_lo;
      3'b110:  w_mdu_res = r_dz ? r_a : (r_neg_r ? -r_hi : r_hi);
      3'b111:  w_mdu_res = r_hi;
      default: w_mdu_res = '0;
    endcase
  end

  always_comb begin
    w_result = '0;
    if (r_state == S_DONE)      w_result = w_mdu_res;
    else if (!ALUControlE[3])   w_result = w_alu;
  end

  assign w_zero  = (w_result == '0);
  assign w_stall = reset & (((r_state == S_IDLE) & w_is_mdu) | (r_state == S_BUSY));
  assign StallE  = w_stall;
  assign PCSrcE  = ~w_stall & ((BranchE & w_zero) | JumpE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_a     <= '0;
      r_op    <= '0;
      r_dz    <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (FlushE) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_is_mdu) begin
          r_op    <= ALUControlE[2:0];
          r_a     <= w_src_a;
          r_dz    <= w_b_zero;
          r_neg_q <= w_signed & (w_src_a[XLEN-1] ^ w_src_b[XLEN-1]);
          r_neg_r <= w_signed & w_src_a[XLEN-1];
          r_b     <= ALUControlE[2] ? w_b_mag : w_src_b;
          if (w_early) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
            r_hi    <= ALUControlE[2] ? w_src_a : '0;
            r_lo    <= ALUControlE[2] ? '1 : '0;
          end else begin
            r_state <= S_BUSY;
            r_cnt   <= CNT_W'(XLEN);
            r_hi    <= '0;
            r_lo    <= ALUControlE[2] ? w_a_mag : w_src_a;
          end
        end
        S_BUSY: begin
          if (r_op[2]) begin
            r_hi <= w_div_ge ? w_div_sub : w_div_shift[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], w_div_ge};
          end else begin
            {r_hi, r_lo} <= {w_mul_sum, r_lo[XLEN-1:1]};
          end
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || FlushE || w_stall) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
    end else begin
      ALUResultM <= w_result;
      WriteDataM <= w_fwd_b;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
    end
  end

endmodule

// File: tb/tb_exec_stage_mdu.sv
// Directed bench for exec_stage_mdu: table-driven ALU and MDU vectors plus
// hand-written flush, reset and branch sequences. Adapts to EXEC_EARLY_OUT_EN.
module tb_exec_stage_mdu;

  localparam int XLEN = 32;
  localparam int FULL_STALL = XLEN + 1;
`ifdef EXEC_EARLY_OUT_EN
  localparam int EO_STALL = 1;
`else
  localparam int EO_STALL = XLEN + 1;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
  logic [4:0]      RdE;
  logic            RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, FlushE;
  logic [1:0]      ResultSrcE, ForwardAE, ForwardBE;
  logic [3:0]      ALUControlE;
  logic [31:0]     PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic            PCSrcE, StallE, RegWriteM, MemWriteM;
  logic [4:0]      RdM;
  logic [1:0]      ResultSrcM;

  int n_checks = 0;
  int n_err    = 0;

  exec_stage_mdu #(.XLEN(XLEN), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
    .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .RdE(RdE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ResultW(ResultW), .FlushE(FlushE),
    .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .StallE(StallE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rd1, rd2, imm, rw;
    logic        alusrc, mw;
    logic [1:0]  fa, fb;
    logic [31:0] exp_res, exp_wd;
  } alu_vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, exp_res;
    bit          eo, scramble;
  } mdu_vec_t;

  alu_vec_t alu_v[13];
  mdu_vec_t mdu_v[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_idle_inputs();
    RD1E = '0; RD2E = '0; PCE = '0; ImmExtE = '0; PCPlus4E = '0; ResultW = '0;
    RdE = '0; RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; ALUSrcE = 0;
    FlushE = 0; ResultSrcE = '0; ForwardAE = '0; ForwardBE = '0; ALUControlE = '0;
  endtask

  task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUControlE = op; RD1E = a; RD2E = b; ForwardAE = 0; ForwardBE = 0; ALUSrcE = 0;
    RegWriteE = 1; MemWriteE = 0; ResultSrcE = 0; RdE = 5'd3; PCPlus4E = 32'h3000;
  endtask

  task automatic run_mdu(input int idx, input mdu_vec_t v);
    int  cnt;
    bit  bub_ok;
    ALUControlE = v.op; RD1E = v.a; RD2E = v.b; ForwardAE = 0; ForwardBE = 0;
    ALUSrcE = 0; RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b10; RdE = 5'd9;
    PCPlus4E = 32'h2000; BranchE = 0; JumpE = 0;
    cnt = 0;
    bub_ok = 1;
    while (cnt < 100) begin
      @(negedge clk);
      if (!StallE) break;
      cnt++;
      @(posedge clk); #1;
      if (RegWriteM !== 0 || MemWriteM !== 0 || ALUResultM !== 0 || RdM !== 0 || ResultSrcM !== 0)
        bub_ok = 0;
      if (v.scramble) begin
        RD1E = 32'h1234_5678; RD2E = 32'h0000_0003; ForwardAE = 2'b01; ResultW = 32'h55;
      end
    end
    check($sformatf("mdu%0d_stall_cycles", idx), cnt, v.eo ? EO_STALL : FULL_STALL);
    check($sformatf("mdu%0d_bubble", idx), {31'b0, bub_ok}, 32'd1);
    @(posedge clk); #1;
    check($sformatf("mdu%0d_result", idx), ALUResultM, v.exp_res);
    check($sformatf("mdu%0d_regwrite", idx), {31'b0, RegWriteM}, 32'd1);
    check($sformatf("mdu%0d_rd", idx), {27'b0, RdM}, 32'd9);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             op       rd1           rd2           imm       rw     alusrc mw  fa     fb     exp_res       exp_wd
    alu_v[0]  = '{4'b0000, 32'd5,        32'd7,        32'd0,    32'd0, 0,     0,  2'b00, 2'b00, 32'd12,       32'd7};
    alu_v[1]  = '{4'b0000, 32'd8,        32'd8,        32'd0,    32'd0, 0,     0,  2'b00, 2'b00, 32'h10,       32'd8};
    alu_v[2]  = '{4'b0001, 32'h99,       32'd3,        32'd0,    32'd0, 0,     0,  2'b10, 2'b00, 32'hD,        32'd3};
    alu_v[3]  = '{4'b0000, 32'd1,        32'h55,       32'd0,    32'd9, 0,     1,  2'b00, 2'b01, 32'd10,       32'd9};
    alu_v[4]  = '{4'b0010, 32'hF0F0,     32'hFF00,     32'd0,    32'd0, 0,     0,  2'b00, 2'b00, 32'hF000,     32'hFF00};
    alu_v[5]  = '{4'b0011, 32'hF0F0,     32'h0F0F,     32'd0,    32'd0, 0,     0,  2'b00, 2'b00, 32'hFFFF,     32'h0F0F};
    alu_v[6]  = '{4'b0101, 32'hFFFFFFFF, 32'd1,        32'd0,    32'd0, 0,     0,  2'b00, 2'b00, 32'd1,        32'd1};
    alu_v[7]  = '{4'b0101, 32'd1,        32'hFFFFFFFF, 32'd0,    32'd0, 0,     0,  2'b00, 2'b00, 32'd0,        32'hFFFFFFFF};
    alu_v[8]  = '{4'b0100, 32'd6,        32'd6,        32'd0,    32'd0, 0,     0,  2'b00, 2'b00, 32'd0,        32'd6};
    alu_v[9]  = '{4'b1010, 32'd6,        32'd6,        32'd0,    32'd0, 0,     0,  2'b00, 2'b00, 32'd0,        32'd6};
    alu_v[10] = '{4'b0000, 32'd5,        32'd77,       32'd100,  32'd0, 1,     0,  2'b00, 2'b00, 32'd105,      32'd77};
    alu_v[11] = '{4'b0000, 32'd1,        32'd77,       32'd0,    32'd0, 0,     0,  2'b11, 2'b10, 32'd106,      32'd105};
    alu_v[12] = '{4'b0001, 32'd3,        32'd5,        32'd0,    32'd0, 0,     0,  2'b00, 2'b00, 32'hFFFFFFFE, 32'd5};

    //             op       a             b             exp_res       eo scramble
    mdu_v[0]  = '{4'b1000, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 0, 0};
    mdu_v[1]  = '{4'b1001, 32'hFFFFFFFF, 32'd2,        32'h00000001, 0, 0};
    mdu_v[2]  = '{4'b1100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 1};
    mdu_v[3]  = '{4'b1110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 0};
    mdu_v[4]  = '{4'b1100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 0};
    mdu_v[5]  = '{4'b1110, 32'd7,        32'hFFFFFFFE, 32'd1,        0, 0};
    mdu_v[6]  = '{4'b1101, 32'd100,      32'd7,        32'd14,       0, 0};
    mdu_v[7]  = '{4'b1111, 32'd100,      32'd7,        32'd2,        0, 0};
    mdu_v[8]  = '{4'b1101, 32'd7,        32'd0,        32'hFFFFFFFF, 1, 0};
    mdu_v[9]  = '{4'b1110, 32'd7,        32'd0,        32'd7,        1, 0};
    mdu_v[10] = '{4'b1100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1, 0};
    mdu_v[11] = '{4'b1110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1, 0};
    mdu_v[12] = '{4'b1100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0};
    mdu_v[13] = '{4'b1110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 0};
    mdu_v[14] = '{4'b1000, 32'd0,        32'd5,        32'd0,        1, 0};
    mdu_v[15] = '{4'b1001, 32'h80000000, 32'h80000000, 32'h40000000, 0, 0};
    mdu_v[16] = '{4'b1101, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0};

    set_idle_inputs();
    reset = 1'b0;
    #2;
    check("reset_aluresult", ALUResultM, 32'd0);
    check("reset_regwrite", {31'b0, RegWriteM}, 32'd0);
    check("reset_stall", {31'b0, StallE}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ALU vectors; ALUResultM of one vector feeds forwarding in the next.
    for (int i = 0; i < 13; i++) begin
      ALUControlE = alu_v[i].op; RD1E = alu_v[i].rd1; RD2E = alu_v[i].rd2;
      ImmExtE = alu_v[i].imm; ResultW = alu_v[i].rw; ALUSrcE = alu_v[i].alusrc;
      MemWriteE = alu_v[i].mw; ForwardAE = alu_v[i].fa; ForwardBE = alu_v[i].fb;
      RegWriteE = 1; ResultSrcE = 2'(i); RdE = 5'(i + 1); PCPlus4E = 32'h1000 + 32'(4 * i);
      @(negedge clk);
      check($sformatf("alu%0d_stall", i), {31'b0, StallE}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("alu%0d_result", i), ALUResultM, alu_v[i].exp_res);
      check($sformatf("alu%0d_writedata", i), WriteDataM, alu_v[i].exp_wd);
      check($sformatf("alu%0d_rd", i), {27'b0, RdM}, 32'(i + 1));
      check($sformatf("alu%0d_pcplus4", i), PCPlus4M, 32'h1000 + 32'(4 * i));
      check($sformatf("alu%0d_memwrite", i), {31'b0, MemWriteM}, {31'b0, alu_v[i].mw});
      check($sformatf("alu%0d_resultsrc", i), {30'b0, ResultSrcM}, 32'(i % 4));
    end

    // MDU vectors, issued back to back.
    for (int i = 0; i < 17; i++) run_mdu(i, mdu_v[i]);

    // Branch: BEQ taken and not taken.
    set_alu(4'b0001, 32'h42, 32'h42);
    BranchE = 1; PCE = 32'h100; ImmExtE = 32'h20;
    @(negedge clk);
    check("beq_taken_pcsrc", {31'b0, PCSrcE}, 32'd1);
    check("beq_pctarget", PCTargetE, 32'h120);
    RD2E = 32'h43;
    #1;
    check("beq_not_taken_pcsrc", {31'b0, PCSrcE}, 32'd0);
    @(posedge clk); #1;
    BranchE = 0;

    // Flush of a normal ALU op loads a bubble.
    set_alu(4'b0000, 32'd2, 32'd2);
    FlushE = 1;
    @(posedge clk); #1;
    check("flush_alu_regwrite", {31'b0, RegWriteM}, 32'd0);
    check("flush_alu_result", ALUResultM, 32'd0);
    FlushE = 0;

    // Flush at cycle 10 of a DIV; jump is suppressed while stalled.
    set_alu(4'b1100, 32'd100, 32'd7);
    JumpE = 1;
    @(negedge clk);
    check("div_jump_suppressed", {31'b0, PCSrcE}, 32'd0);
    check("div_stall_issue", {31'b0, StallE}, 32'd1);
    repeat (10) begin @(posedge clk); #1; end
    FlushE = 1; JumpE = 0;
    @(negedge clk);
    check("div_stall_cycle10", {31'b0, StallE}, 32'd1);
    @(posedge clk); #1;
    check("flush_div_regwrite", {31'b0, RegWriteM}, 32'd0);
    FlushE = 0;
    set_alu(4'b0000, 32'd1, 32'd1);
    @(negedge clk);
    check("after_flush_stall", {31'b0, StallE}, 32'd0);
    @(posedge clk); #1;
    check("after_flush_result", ALUResultM, 32'd2);
    check("after_flush_regwrite", {31'b0, RegWriteM}, 32'd1);

    // Reset mid-MUL: outputs clear at once and the FSM restarts idle.
    set_alu(4'b1000, 32'd3, 32'd5);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midop_reset_stall", {31'b0, StallE}, 32'd0);
    check("midop_reset_result", ALUResultM, 32'd0);
    check("midop_reset_regwrite", {31'b0, RegWriteM}, 32'd0);
    set_alu(4'b0000, 32'd3, 32'd4);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_reset_stall", {31'b0, StallE}, 32'd0);
    @(posedge clk); #1;
    check("post_reset_result", ALUResultM, 32'd7);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
